// File: rtl/riscv_i32_trace_capture_if.sv
// Readout handshake between the trace-capture controller (master) and a debug/APB host (slave).
interface riscv_i32_trace_capture_if;
    logic        rd_valid;
    logic        rd_ack;
    logic [31:0] rd_pc;
    logic        rd_branch_taken;
    logic [31:0] rd_branch_target;

    modport master (
        output rd_valid, rd_pc, rd_branch_taken, rd_branch_target,
        input  rd_ack
    );

    modport slave (
        input  rd_valid, rd_pc, rd_branch_taken, rd_branch_target,
        output rd_ack
    );
endinterface

// File: rtl/riscv_i32_trace_capture.sv
// Trace-capture controller: circular retire-record buffer sequenced through arm, history, post-trigger capture and readout.
// Optional compressed branch trace is enabled by defining RISCV_I32_TRACE_CAPTURE_BRANCH_ONLY_EN.
module riscv_i32_trace_capture #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       clk__enable,
    input  logic                       reset_n,
    input  logic                       trace_valid,
    input  logic [31:0]                pc,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    input  logic                       ctl_arm,
    input  logic                       ctl_abort,
    input  logic [31:0]                trigger_pc,
    input  logic [DEPTH_LOG2:0]        post_count,
    riscv_i32_trace_capture_if.master  rd,
    output logic [1:0]                 state,
    output logic [DEPTH_LOG2:0]        fill,
    output logic                       wrapped
);
    localparam int D = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(D);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0]   rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic                    wrapped_q, wrapped_d;
    logic [DEPTH_LOG2:0]     postCnt_q, postCnt_d;
    logic [64:0]             mem_q [D];

    logic                    capturing;
    logic                    triggerHit;
    logic                    logEn;
    logic                    wrEn;
    logic                    rdValid;
    logic [DEPTH_LOG2:0]     postClamp;
    logic [DEPTH_LOG2:0]     postLoad;
    logic [64:0]             headRec;

    assign capturing  = (state_q == ARMED) || (state_q == CAPTURE);
    assign triggerHit = (state_q == ARMED) && trace_valid && (pc == trigger_pc);

`ifdef RISCV_I32_TRACE_CAPTURE_BRANCH_ONLY_EN
    // The trigger record is kept even when it is not a taken branch.
    assign logEn = capturing && trace_valid && (branch_taken || triggerHit);
`else
    assign logEn = capturing && trace_valid;
`endif

    assign wrEn = logEn && !ctl_abort;

    assign postClamp = (post_count == '0)  ? (DEPTH_LOG2 + 1)'(1) :
                       (post_count > FULL) ? FULL : post_count;
    assign postLoad  = postClamp - 1'b1;

    assign rdValid = (state_q == DONE) && (fill_q != '0);
    assign headRec = mem_q[rdPtr_q];

    always_comb begin
        state_d   = state_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        fill_d    = fill_q;
        wrapped_d = wrapped_q;
        postCnt_d = postCnt_q;

        if (ctl_abort) begin
            state_d   = IDLE;
            fill_d    = '0;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctl_arm) begin
                        state_d   = ARMED;
                        fill_d    = '0;
                        wrPtr_d   = '0;
                        rdPtr_d   = '0;
                        wrapped_d = 1'b0;
                    end
                end
                ARMED, CAPTURE: begin
                    // A full buffer drops its oldest record to make room for the new one.
                    if (logEn) begin
                        wrPtr_d = wrPtr_q + 1'b1;
                        if (fill_q == FULL) begin
                            rdPtr_d   = rdPtr_q + 1'b1;
                            wrapped_d = 1'b1;
                        end else begin
                            fill_d = fill_q + 1'b1;
                        end
                    end
                    if (state_q == ARMED) begin
                        if (triggerHit) begin
                            postCnt_d = postLoad;
                            state_d   = (postLoad == '0) ? DONE : CAPTURE;
                        end
                    end else if (logEn) begin
                        postCnt_d = postCnt_q - 1'b1;
                        if (postCnt_q == (DEPTH_LOG2 + 1)'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (fill_q == '0) begin
                        state_d = IDLE;
                    end else if (rd.rd_ack) begin
                        rdPtr_d = rdPtr_q + 1'b1;
                        fill_d  = fill_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fill_q    <= '0;
            wrapped_q <= 1'b0;
            postCnt_q <= '0;
        end else if (clk__enable) begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            fill_q    <= fill_d;
            wrapped_q <= wrapped_d;
            postCnt_q <= postCnt_d;
        end
    end

    // Storage is not reset; only records between the pointers are ever presented.
    always_ff @(posedge clk) begin
        if (reset_n && clk__enable && wrEn) begin
            mem_q[wrPtr_q] <= {pc, branch_taken, branch_target};
        end
    end

    assign rd.rd_valid         = rdValid;
    assign rd.rd_pc            = rdValid ? headRec[64:33] : 32'd0;
    assign rd.rd_branch_taken  = rdValid ? headRec[32]    : 1'b0;
    assign rd.rd_branch_target = rdValid ? headRec[31:0]  : 32'd0;

    assign state   = state_q;
    assign fill    = fill_q;
    assign wrapped = wrapped_q;
endmodule

// File: tb/tb_riscv_i32_trace_capture.sv
// Scoreboard bench for riscv_i32_trace_capture: directed retire traces push expected records, a monitor checks each popped record.
module tb_riscv_i32_trace_capture;
    localparam int DEPTH_LOG2 = 4;
    localparam int D = 16;

    logic                clk = 1'b0;
    logic                clk__enable;
    logic                reset_n;
    logic                trace_valid;
    logic [31:0]         pc;
    logic                branch_taken;
    logic [31:0]         branch_target;
    logic                ctl_arm;
    logic                ctl_abort;
    logic [31:0]         trigger_pc;
    logic [DEPTH_LOG2:0] post_count;
    logic [1:0]          state;
    logic [DEPTH_LOG2:0] fill;
    logic                wrapped;

    riscv_i32_trace_capture_if rdIf ();

    riscv_i32_trace_capture #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .clk__enable   (clk__enable),
        .reset_n       (reset_n),
        .trace_valid   (trace_valid),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ctl_arm       (ctl_arm),
        .ctl_abort     (ctl_abort),
        .trigger_pc    (trigger_pc),
        .post_count    (post_count),
        .rd            (rdIf.master),
        .state         (state),
        .fill          (fill),
        .wrapped       (wrapped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
    } rec_t;

    rec_t expQ[$];
    rec_t monRec;
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Retire one instruction; the model keeps at most D records, oldest dropped first.
    task automatic applyStimulus(input logic [31:0] p, input logic tk, input logic [31:0] tg, input bit logged);
        pc            = p;
        branch_taken  = tk;
        branch_target = tg;
        trace_valid   = 1'b1;
        if (logged) begin
            expQ.push_back('{pc: p, tk: tk, tg: tg});
            if (expQ.size() > D) expQ.delete(0);
        end
        @(posedge clk); #1;
        trace_valid = 1'b0;
    endtask

    task automatic pulseArm();
        ctl_arm = 1'b1;
        @(posedge clk); #1;
        ctl_arm = 1'b0;
        expQ.delete();
    endtask

    task automatic readOne();
        int waitCnt = 0;
        while (!rdIf.rd_valid && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!rdIf.rd_valid) begin
            checkOutput("rdValidTimeout", 32'd0, 32'd1);
        end else begin
            rdIf.rd_ack = 1'b1;
            @(posedge clk); #1;
            rdIf.rd_ack = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rdIf.rd_valid && rdIf.rd_ack) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRecordPc", rdIf.rd_pc, 32'hFFFF_FFFF);
            end else begin
                monRec = expQ.pop_front();
                checkOutput("recPc", rdIf.rd_pc, monRec.pc);
                checkOutput("recTaken", {31'd0, rdIf.rd_branch_taken}, {31'd0, monRec.tk});
                checkOutput("recTarget", rdIf.rd_branch_target, monRec.tg);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk__enable   = 1'b1;
        reset_n       = 1'b0;
        trace_valid   = 1'b0;
        pc            = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        ctl_arm       = 1'b0;
        ctl_abort     = 1'b0;
        trigger_pc    = '0;
        post_count    = '0;
        rdIf.rd_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", {30'd0, state}, 32'd0);
        checkOutput("resetFill", {27'd0, fill}, 32'd0);
        checkOutput("resetWrapped", {31'd0, wrapped}, 32'd0);
        checkOutput("resetRdValid", {31'd0, rdIf.rd_valid}, 32'd0);
        checkOutput("resetRdPc", rdIf.rd_pc, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

`ifdef RISCV_I32_TRACE_CAPTURE_BRANCH_ONLY_EN
        trigger_pc = 32'h1000;
        post_count = 5'd3;
        pulseArm();
        checkOutput("boArmState", {30'd0, state}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h1000 + 32'(4 * i), (i == 2 || i == 5),
                          (i == 2 || i == 5) ? 32'h2000 + 32'(16 * i) : 32'd0,
                          (i == 0 || i == 2 || i == 5));
            if (i == 0) checkOutput("boTriggerState", {30'd0, state}, 32'd2);
        end
        checkOutput("boDoneState", {30'd0, state}, 32'd3);
        checkOutput("boFill", {27'd0, fill}, 32'd3);
        for (int i = 0; i < 3; i++) readOne();
        checkOutput("boQueueEmpty", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;
        checkOutput("boIdle", {30'd0, state}, 32'd0);
`else
        // Basic capture around a trigger at 0x104.
        trigger_pc = 32'h104;
        post_count = 5'd2;
        pulseArm();
        checkOutput("armState", {30'd0, state}, 32'd1);
        applyStimulus(32'h100, 1'b0, 32'd0, 1'b1);
        checkOutput("armedFill", {27'd0, fill}, 32'd1);
        applyStimulus(32'h104, 1'b0, 32'd0, 1'b1);
        checkOutput("triggerState", {30'd0, state}, 32'd2);
        applyStimulus(32'h108, 1'b1, 32'h300, 1'b1);
        checkOutput("doneState", {30'd0, state}, 32'd3);
        checkOutput("doneRdValid", {31'd0, rdIf.rd_valid}, 32'd1);
        checkOutput("doneFill", {27'd0, fill}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            readOne();
            checkOutput("drainFill", {27'd0, fill}, 32'(2 - i));
        end
        checkOutput("basicQueueEmpty", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;
        checkOutput("basicIdle", {30'd0, state}, 32'd0);

        // Wrap: 21 records into a 16-deep buffer, then a readout stall.
        trigger_pc = 32'h50;
        post_count = 5'd1;
        pulseArm();
        for (int i = 0; i < 20; i++) applyStimulus(32'(4 * i), i[0], 32'h1000 + 32'(i), 1'b1);
        applyStimulus(32'h50, 1'b0, 32'd0, 1'b1);
        checkOutput("wrapState", {30'd0, state}, 32'd3);
        checkOutput("wrapFlag", {31'd0, wrapped}, 32'd1);
        checkOutput("wrapFill", {27'd0, fill}, 32'd16);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stallPc", rdIf.rd_pc, 32'h14);
            checkOutput("stallFill", {27'd0, fill}, 32'd16);
            @(posedge clk); #1;
        end
        readOne();
        checkOutput("singleAckFill", {27'd0, fill}, 32'd15);
        checkOutput("singleAckPc", rdIf.rd_pc, 32'h18);
        for (int i = 0; i < 15; i++) readOne();
        checkOutput("wrapQueueEmpty", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;
        checkOutput("wrapIdle", {30'd0, state}, 32'd0);

        // Abort in CAPTURE with a retire in the same cycle.
        trigger_pc = 32'h200;
        post_count = 5'd10;
        pulseArm();
        for (int i = 0; i < 5; i++) applyStimulus(32'h1F8 + 32'(4 * i), 1'b0, 32'd0, 1'b1);
        checkOutput("preAbortState", {30'd0, state}, 32'd2);
        checkOutput("preAbortFill", {27'd0, fill}, 32'd5);
        ctl_abort   = 1'b1;
        trace_valid = 1'b1;
        pc          = 32'h20C;
        @(posedge clk); #1;
        ctl_abort   = 1'b0;
        trace_valid = 1'b0;
        expQ.delete();
        checkOutput("abortState", {30'd0, state}, 32'd0);
        checkOutput("abortFill", {27'd0, fill}, 32'd0);
        checkOutput("abortRdValid", {31'd0, rdIf.rd_valid}, 32'd0);
        checkOutput("abortWrapped", {31'd0, wrapped}, 32'd0);

        // post_count of 0 behaves as 1: trigger goes straight to DONE.
        trigger_pc = 32'h400;
        post_count = 5'd0;
        pulseArm();
        applyStimulus(32'h3FC, 1'b0, 32'd0, 1'b1);
        applyStimulus(32'h400, 1'b1, 32'h500, 1'b1);
        checkOutput("zeroPostState", {30'd0, state}, 32'd3);
        checkOutput("zeroPostFill", {27'd0, fill}, 32'd2);
        readOne();
        readOne();
        checkOutput("zeroPostQueueEmpty", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;

        // Re-arm is ignored mid-capture; reset during readout clears everything.
        trigger_pc = 32'h300;
        post_count = 5'd4;
        pulseArm();
        applyStimulus(32'h300, 1'b0, 32'd0, 1'b1);
        ctl_arm = 1'b1;
        @(posedge clk); #1;
        ctl_arm = 1'b0;
        checkOutput("rearmState", {30'd0, state}, 32'd2);
        checkOutput("rearmFill", {27'd0, fill}, 32'd1);
        for (int i = 1; i < 4; i++) applyStimulus(32'h300 + 32'(4 * i), 1'b0, 32'd0, 1'b1);
        checkOutput("preResetFill", {27'd0, fill}, 32'd4);
        checkOutput("preResetState", {30'd0, state}, 32'd3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        expQ.delete();
        checkOutput("midResetState", {30'd0, state}, 32'd0);
        checkOutput("midResetFill", {27'd0, fill}, 32'd0);
        checkOutput("midResetRdValid", {31'd0, rdIf.rd_valid}, 32'd0);
        checkOutput("midResetRdPc", rdIf.rd_pc, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
